// File: rtl/gbp_update_ctrl.sv
// rtl/gbp_update_ctrl.sv - in-order branch-resolution tracker feeding the gshare update channel
// Predicted conditional branches are queued at fetch; each in-order resolve pops
// the head and produces one registered update beat, a mispredict flag and counts.
module gbp_update_ctrl #(
   parameter int VLEN       = 64,
   parameter int INDEX_BITS = 10,
   parameter int DEPTH      = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  debug_mode_i,
   input  logic                  flush_i,
   input  logic                  alloc_valid_i,
   output logic                  alloc_ready_o,
   input  logic [VLEN-1:0]       alloc_pc_i,
   input  logic                  alloc_taken_i,
   input  logic [INDEX_BITS-1:0] alloc_index_i,
   input  logic                  resolve_valid_i,
   input  logic                  resolve_taken_i,
   output logic                  bht_update_valid_o,
   output logic [VLEN-1:0]       bht_update_pc_o,
   output logic                  bht_update_taken_o,
   output logic [INDEX_BITS-1:0] bht_update_index_o,
   output logic                  mispredict_o,
   output logic                  resolve_err_o,
   output logic [31:0]           branch_cnt_o,
   output logic [31:0]           mispredict_cnt_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [VLEN-1:0]       pc_mem    [DEPTH];
   logic                  taken_mem [DEPTH];
   logic [INDEX_BITS-1:0] idx_mem   [DEPTH];

   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_next;
   logic             ready;
   logic             alloc_acc;
   logic             res_acc;
   logic             misp_now;
   logic [31:0]      branch_cnt;
   logic [31:0]      misp_cnt;

   assign alloc_ready_o    = ready;
   assign branch_cnt_o     = branch_cnt;
   assign mispredict_cnt_o = misp_cnt;

   // Acceptance qualifiers and next occupancy; a flush empties the queue after the resolve is taken.
   always_comb begin
      alloc_acc  = alloc_valid_i && ready && !flush_i;
      res_acc    = resolve_valid_i && (count != '0);
      misp_now   = taken_mem[rptr] ^ resolve_taken_i;
      count_next = count;
      if (flush_i) begin
         count_next = '0;
      end else if (alloc_acc && !res_acc) begin
         count_next = count + CNT_ONE;
      end else if (!alloc_acc && res_acc) begin
         count_next = count - CNT_ONE;
      end
   end

   // Entry storage needs no reset: only slots between rptr and wptr are ever read.
   always_ff @(posedge clk_i) begin
      if (alloc_acc) begin
         pc_mem[wptr]    <= alloc_pc_i;
         taken_mem[wptr] <= alloc_taken_i;
         idx_mem[wptr]   <= alloc_index_i;
      end
   end

   // Pointers, occupancy and the registered ready flag (no bypass from a same-cycle resolve).
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ready <= 1'b1;
      end else begin
         if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
         end else begin
            if (alloc_acc) wptr <= wptr + PTR_ONE;
            if (res_acc)   rptr <= rptr + PTR_ONE;
         end
         count <= count_next;
         ready <= (count_next != CNT_FULL);
      end
   end

   // Update beat: one-cycle pulse, suppressed (but still popped) in debug mode.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         bht_update_valid_o <= 1'b0;
         bht_update_pc_o    <= '0;
         bht_update_taken_o <= 1'b0;
         bht_update_index_o <= '0;
         mispredict_o       <= 1'b0;
         resolve_err_o      <= 1'b0;
      end else begin
         bht_update_valid_o <= res_acc && !debug_mode_i;
         mispredict_o       <= res_acc && !debug_mode_i && misp_now;
         if (res_acc) begin
            bht_update_pc_o    <= pc_mem[rptr];
            bht_update_taken_o <= resolve_taken_i;
            bht_update_index_o <= idx_mem[rptr];
         end
         if (resolve_valid_i && (count == '0)) resolve_err_o <= 1'b1;
      end
   end

   // Saturating performance counters; they count regardless of debug mode.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         branch_cnt <= '0;
         misp_cnt   <= '0;
      end else if (res_acc) begin
         if (branch_cnt != 32'hFFFF_FFFF) branch_cnt <= branch_cnt + 32'd1;
         if (misp_now && (misp_cnt != 32'hFFFF_FFFF)) misp_cnt <= misp_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_gbp_update_ctrl.sv
// tb/tb_gbp_update_ctrl.sv - self-checking bench for gbp_update_ctrl
module tb_gbp_update_ctrl;
   localparam int VLEN = 64;
   localparam int IB = 10;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic debug_mode = 1'b0, flush = 1'b0;
   logic alloc_valid = 1'b0, alloc_ready, alloc_taken = 1'b0;
   logic [VLEN-1:0] alloc_pc = '0;
   logic [IB-1:0] alloc_index = '0;
   logic resolve_valid = 1'b0, resolve_taken = 1'b0;
   logic upd_valid, upd_taken, misp, res_err;
   logic [VLEN-1:0] upd_pc;
   logic [IB-1:0] upd_index;
   logic [31:0] bcnt, mcnt;

   gbp_update_ctrl #(.VLEN(VLEN), .INDEX_BITS(IB), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .debug_mode_i(debug_mode), .flush_i(flush),
      .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_pc_i(alloc_pc),
      .alloc_taken_i(alloc_taken), .alloc_index_i(alloc_index),
      .resolve_valid_i(resolve_valid), .resolve_taken_i(resolve_taken),
      .bht_update_valid_o(upd_valid), .bht_update_pc_o(upd_pc),
      .bht_update_taken_o(upd_taken), .bht_update_index_o(upd_index),
      .mispredict_o(misp), .resolve_err_o(res_err),
      .branch_cnt_o(bcnt), .mispredict_cnt_o(mcnt));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a plain FIFO of predicted branches.
   typedef struct {
      logic [VLEN-1:0] pc;
      logic            t;
      logic [IB-1:0]   idx;
   } ent_t;
   ent_t mq[$];
   ent_t h;
   ent_t n;
   logic e_valid = 1'b0, e_misp = 1'b0, e_err = 1'b0, e_ready = 1'b1, e_taken = 1'b0;
   logic [VLEN-1:0] e_pc = '0;
   logic [IB-1:0] e_idx = '0;
   logic [31:0] e_bcnt = '0, e_mcnt = '0;
   logic was_ready, wrong;
   bit preload = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         e_valid = 1'b0; e_misp = 1'b0; e_err = 1'b0; e_ready = 1'b1;
         e_pc = '0; e_taken = 1'b0; e_idx = '0; e_bcnt = '0; e_mcnt = '0;
      end else begin
         was_ready = e_ready;
         if (preload) e_bcnt = 32'hFFFF_FFFF;
         e_valid = 1'b0;
         e_misp = 1'b0;
         if (resolve_valid) begin
            if (mq.size() > 0) begin
               h = mq.pop_front();
               wrong = (h.t != resolve_taken);
               e_valid = !debug_mode;
               e_misp = !debug_mode && wrong;
               e_pc = h.pc;
               e_taken = resolve_taken;
               e_idx = h.idx;
               if (e_bcnt != 32'hFFFF_FFFF) e_bcnt = e_bcnt + 1;
               if (wrong && e_mcnt != 32'hFFFF_FFFF) e_mcnt = e_mcnt + 1;
            end else begin
               e_err = 1'b1;
            end
         end
         if (flush) begin
            mq.delete();
         end else if (alloc_valid && was_ready) begin
            n.pc = alloc_pc; n.t = alloc_taken; n.idx = alloc_index;
            mq.push_back(n);
         end
         e_ready = (mq.size() != DEPTH);
      end
   end

   // Compare the DUT against the model on every falling edge.
   always @(negedge clk) begin
      check("alloc_ready", alloc_ready, e_ready);
      check("update_valid", upd_valid, e_valid);
      check("mispredict", misp, e_misp);
      check("resolve_err", res_err, e_err);
      check("mispredict_cnt", mcnt, e_mcnt);
      if (!preload) check("branch_cnt", bcnt, e_bcnt);
      if (e_valid) begin
         check("update_pc", upd_pc, e_pc);
         check("update_taken", upd_taken, e_taken);
         check("update_index", upd_index, e_idx);
      end
   end

   task automatic step(input logic av, input logic [63:0] pc, input logic t, input logic [9:0] idx,
                       input logic rv, input logic rt, input logic fl, input logic dbg);
      alloc_valid = av; alloc_pc = pc; alloc_taken = t; alloc_index = idx;
      resolve_valid = rv; resolve_taken = rt; flush = fl; debug_mode = dbg;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      alloc_valid = 0; resolve_valid = 0; flush = 0; debug_mode = 0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
   endtask

   int beats;

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset_ready", alloc_ready, 1);
      check("reset_valid", upd_valid, 0);
      check("reset_bcnt", bcnt, 0);
      idle(1);

      // Basic alloc then resolve two cycles later.
      step(1, 64'h8000_0000, 1, 10'h15, 0, 0, 0, 0);
      idle(1);
      step(0, 0, 0, 0, 1, 1, 0, 0);
      check("t1_valid", upd_valid, 1);
      check("t1_pc", upd_pc, 64'h8000_0000);
      check("t1_taken", upd_taken, 1);
      check("t1_index", upd_index, 10'h15);
      check("t1_misp", misp, 0);
      check("t1_bcnt", bcnt, 1);
      idle(1);

      // Fill, reject the ninth, drain in order.
      do_reset();
      for (int i = 0; i < 8; i++) step(1, 64'h100 + 4 * i, (i % 2 == 0), 10'(i), 0, 0, 0, 0);
      check("t2_full", alloc_ready, 0);
      step(1, 64'h200, 1, 10'h3ff, 0, 0, 0, 0);
      beats = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 0, 0, 1, 1, 0, 0);
         if (upd_valid) beats++;
      end
      check("t2_beats", beats, 8);
      check("t2_mcnt", mcnt, 4);
      check("t2_rptr", dut.rptr, 0);
      check("t2_wptr", dut.wptr, 0);
      step(0, 0, 0, 0, 1, 1, 0, 0);
      check("t2_ninth_dropped", res_err, 1);
      check("t2_no_beat", upd_valid, 0);

      // Sustained alloc+resolve at occupancy 3.
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 64'h1000 + 4 * i, 1, 10'(i), 0, 0, 0, 0);
      for (int i = 0; i < 20; i++)
         step(1, {$urandom, $urandom}, 1'($urandom), 10'($urandom), 1, 1'($urandom), 0, 0);
      check("t3_count", dut.count, 3);
      check("t3_ready", alloc_ready, 1);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 0, 0);
      check("t3_bcnt", bcnt, 23);

      // Flush with a same-cycle resolve and a dropped allocation.
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 64'h4000 + 8 * i, 0, 10'(i), 0, 0, 0, 0);
      step(1, 64'h9999, 1, 10'h1, 1, 0, 1, 0);
      check("t4_valid", upd_valid, 1);
      check("t4_pc", upd_pc, 64'h4000);
      step(0, 0, 0, 0, 1, 0, 0, 0);
      check("t4_err", res_err, 1);
      check("t4_no_beat", upd_valid, 0);

      // Debug mode pops without update beats.
      do_reset();
      for (int i = 0; i < 2; i++) step(1, 64'h500 + 4 * i, 0, 10'(i), 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 0, 1, 1, 0, 1);
         check("t5_valid", upd_valid, 0);
      end
      check("t5_bcnt", bcnt, 2);
      check("t5_mcnt", mcnt, 2);

      // Empty resolve error and counter saturation.
      do_reset();
      step(0, 0, 0, 0, 1, 1, 0, 0);
      check("t6_err", res_err, 1);
      check("t6_bcnt", bcnt, 0);
      step(1, 64'h600, 1, 10'h6, 0, 0, 0, 0);
      idle(1);
      preload = 1'b1;
      force dut.branch_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.branch_cnt;
      step(0, 0, 0, 0, 1, 0, 0, 0);
      preload = 1'b0;
      check("t6_sat", bcnt, 32'hFFFF_FFFF);
      check("t6_mcnt", mcnt, 1);

      // Randomized traffic with a mid-run reset.
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if (c == 300) do_reset();
         step(($urandom % 10) < 6, {$urandom, $urandom}, 1'($urandom), 10'($urandom),
              ($urandom % 10) < 5, 1'($urandom), ($urandom % 100) < 3, ($urandom % 10) == 0);
      end
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gbp_update_ctrl.md
# gbp_update_ctrl

In-order branch-resolution tracker that drives the update channel of the global (gshare) branch predictor. At fetch it captures each predicted conditional branch (PC, predicted direction, predictor metadata index) in a circular queue. When the branch resolves in the backend it pairs the actual outcome with the stored entry and emits one registered `bht_update` beat back to the predictor. It also flags mispredictions and keeps performance counters.

## Interface
- `VLEN`, 64, virtual PC width
- `INDEX_BITS`, 10, predictor metadata index width (global predictor index bits)
- `DEPTH`, 8, in-flight branch entries; power of two, ≥2
- `clk_i` in 1: clock
- `rst_i` in 1: reset, asynchronous, active-high
- `debug_mode_i` in 1: suppress predictor updates while high
- `flush_i` in 1: squash all unresolved entries
- `alloc_valid_i` in 1: new predicted branch from fetch
- `alloc_ready_o` out 1: queue can accept an entry
- `alloc_pc_i` in VLEN: branch PC
- `alloc_taken_i` in 1: predicted direction
- `alloc_index_i` in INDEX_BITS: prediction metadata index
- `resolve_valid_i` in 1: oldest in-flight branch resolved
- `resolve_taken_i` in 1: actual direction
- `bht_update_valid_o` out 1: update beat valid
- `bht_update_pc_o` out VLEN: update PC
- `bht_update_taken_o` out 1: actual direction
- `bht_update_index_o` out INDEX_BITS: metadata index to update
- `mispredict_o` out 1: predicted != actual, qualified by update valid
- `resolve_err_o` out 1: sticky, resolve received while queue empty
- `branch_cnt_o` out 32: resolved branches, saturating
- `mispredict_cnt_o` out 32: mispredicted branches, saturating

## Operation
- Storage: DEPTH entries {pc, pred_taken, index}; read/write pointers log2(DEPTH) bits wrapping modulo DEPTH; occupancy counter 0..DEPTH.
- `alloc_ready_o` = (count != DEPTH); this is a registered comparison with no same-cycle bypass from resolve. An allocation is accepted when `alloc_valid_i && alloc_ready_o && !flush_i`: write at wptr, wptr+1.
- Resolve is accepted when `resolve_valid_i && count != 0`: read head at rptr, rptr+1, register the update beat. Resolves must arrive in allocation order.
- Resolve while count == 0: ignored, no beat, `resolve_err_o` sets and stays set until reset.
- Simultaneous accepted alloc and resolve: count unchanged, both pointers advance.
- Flush: the same-cycle resolve is honored first and its beat is emitted. Then rptr = wptr = 0 and count = 0. The same-cycle allocation is dropped.
- `debug_mode_i` high at resolve: entry is still popped and counters still count, but `bht_update_valid_o` stays 0 for that beat.
- Mispredict = stored pred_taken XOR resolve_taken_i.
- Counters: `branch_cnt_o` increments on every accepted resolve. `mispredict_cnt_o` increments on every accepted resolve that mispredicts, independent of debug mode. Both saturate at 0xFFFF_FFFF.

## Timing
- Reset: pointers 0, count 0, `alloc_ready_o`=1, all update outputs 0, `mispredict_o`=0, `resolve_err_o`=0, counters 0.
- Resolve→update latency: exactly 1 cycle. Outputs are registered and `bht_update_valid_o` is a single-cycle pulse per beat.
- Alloc→resolvable: entry visible to a resolve in the cycle after acceptance. Same-cycle alloc+resolve on an empty queue counts as a resolve error.
- Full→ready: `alloc_ready_o` rises the cycle after the resolve that freed the slot.
- Throughput: one alloc and one resolve per cycle sustained.
- Reset asserted mid-operation: all state clears asynchronously and any pending beat is lost.

## Test plan
- Reset, then alloc {pc=0x8000_0000, taken=1, idx=0x15}, resolve taken=1 two cycles later → one cycle later: update valid, pc=0x8000_0000, taken=1, index=0x15, mispredict_o=0, branch_cnt=1.
- Fill 8 entries (pcs 0x100+4i, pred alternating) → alloc_ready_o=0 and a 9th alloc is not stored. Resolve all 8 with taken=1 → 8 in-order beats, mispredict_cnt=4, pointers wrap back to 0.
- Simultaneous alloc+resolve at count=3 for 20 cycles → count stays 3, beats in allocation order, no drops.
- Flush with 5 entries plus same-cycle resolve → one beat for the head; the following resolve sets resolve_err_o=1 and produces no beat.
- debug_mode_i=1 during 2 resolves → no update valid, branch_cnt +2.
- Resolve on empty after reset → resolve_err_o=1, counters stay 0. Preload branch_cnt=0xFFFF_FFFF via force, then resolve → counter stays 0xFFFF_FFFF.
